// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Memory-access stage between the MEM pipeline stage and the data port of a
//   word-addressed, big-endian internal memory. One request is taken per
//   valid/ready handshake and exactly one response comes back for it.
//   Loads get byte-lane extraction and sign/zero extension. Misaligned,
//   out-of-window and illegal-mode requests return an error and never touch
//   the bus.
//
// Parameters
//   MEM_BASE   byte address of the first memory word
//   MEM_WORDS  window size in 32-bit words
//
// Ports
//   clk           system clock (FSM on posedge, memory samples on negedge)
//   reset_n       asynchronous active-low reset
//   req_valid     request present
//   req_ready     unit can accept (IDLE only)
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   req_rw        0 = load, 1 = store
//   req_mode      0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_signed    load extension: 1 = sign, 0 = zero
//   resp_valid    response present, held until resp_ready
//   resp_ready    consumer accepts the response
//   resp_rdata    extended load data (0 for stores and errors)
//   resp_error    request rejected, no bus access made
//   data_address  byte address to memory
//   data_bus      bidirectional data; driven only during a store access
//   data_cs       memory chip select, high only during the access cycle
//   data_rw       latched rw during the access cycle, else 0
//   data_mode     latched mode during the access cycle, else 0
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_rw,
    input  logic [1:0]  req_mode,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] data_address,
    inout  tri   [31:0] data_bus,
    output logic        data_cs,
    output logic        data_rw,
    output logic [1:0]  data_mode
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Window bounds in 33 bits so a window touching 2^32 cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, MEM_BASE};
    localparam logic [32:0] WIN_HI = {1'b0, MEM_BASE} + (33'(MEM_WORDS) << 2) - 33'd1;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rw;
    logic [1:0]  r_mode;
    logic        r_signed;
    logic        r_cs;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_rdata;
    logic        r_error;

    logic        w_in_window;
    logic        w_misaligned;
    logic        w_req_error;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_data;

    // ------------------------------------------------------------------
    // Request screening (evaluated on the live request in IDLE)
    // ------------------------------------------------------------------
    assign w_in_window  = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} <= WIN_HI);
    assign w_misaligned = ((req_mode == 2'd1) && req_addr[0]) ||
                          ((req_mode == 2'd2) && (req_addr[1:0] != 2'b00));
    assign w_req_error  = (req_mode == 2'd3) || w_misaligned || !w_in_window;

    // ------------------------------------------------------------------
    // Load lane extraction; byte offset 0 is the most significant byte.
    // ------------------------------------------------------------------
    always_comb begin
        w_lane_byte = data_bus[31:24];
        case (r_addr[1:0])
            2'd0: w_lane_byte = data_bus[31:24];
            2'd1: w_lane_byte = data_bus[23:16];
            2'd2: w_lane_byte = data_bus[15:8];
            2'd3: w_lane_byte = data_bus[7:0];
            default: w_lane_byte = data_bus[31:24];
        endcase
    end

    // Halfword requests that reach the bus are aligned, so offset is 0 or 2.
    assign w_lane_half = (r_addr[1:0] == 2'd0) ? data_bus[31:16] : data_bus[15:0];

    always_comb begin
        w_load_data = data_bus;
        case (r_mode)
            2'd0: w_load_data = r_signed ? {{24{w_lane_byte[7]}}, w_lane_byte}
                                         : {24'b0, w_lane_byte};
            2'd1: w_load_data = r_signed ? {{16{w_lane_half[15]}}, w_lane_half}
                                         : {16'b0, w_lane_half};
            default: w_load_data = data_bus;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rw         <= 1'b0;
            r_mode       <= '0;
            r_signed     <= 1'b0;
            r_cs         <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_rw        <= req_rw;
                        r_mode      <= req_mode;
                        r_signed    <= req_signed;
                        r_req_ready <= 1'b0;
                        if (w_req_error) begin
                            // Rejected requests skip the bus entirely.
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_error      <= 1'b1;
                            r_rdata      <= '0;
                        end else begin
                            r_state <= S_ACCESS;
                            r_cs    <= 1'b1;
                        end
                    end
                end

                S_ACCESS: begin
                    // Memory has sampled on the intervening negedge; read
                    // data is valid on the bus at this edge.
                    r_cs         <= 1'b0;
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_error      <= 1'b0;
                    r_rdata      <= r_rw ? 32'd0 : w_load_data;
                end

                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_rdata      <= '0;
                        r_error      <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_cs         <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Bus-side signals are gated by r_cs so an asynchronous reset
    // releases chip select and the data bus at once.
    // ------------------------------------------------------------------
    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_rdata;
    assign resp_error   = r_error;
    assign data_cs      = r_cs;
    assign data_rw      = r_cs ? r_rw   : 1'b0;
    assign data_mode    = r_cs ? r_mode : 2'd0;
    assign data_address = r_cs ? r_addr : 32'd0;
    assign data_bus     = (r_cs && r_rw) ? r_wdata : 32'bz;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit. A word-level memory stand-in answers
//   the data port; a byte-addressed reference model predicts every response,
//   and a compare process checks each valid response cycle against it.
//   Each directed vector also carries a hand-computed literal.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 4096;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_rw;
    logic [1:0]  req_mode;
    logic        req_signed;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] data_address;
    tri   [31:0] data_bus;
    logic        data_cs;
    logic        data_rw;
    logic [1:0]  data_mode;

    int n_cmp = 0;
    int n_bad = 0;

    load_store_unit #(
        .MEM_BASE  (BASE),
        .MEM_WORDS (WORDS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rw       (req_rw),
        .req_mode     (req_mode),
        .req_signed   (req_signed),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .data_address (data_address),
        .data_bus     (data_bus),
        .data_cs      (data_cs),
        .data_rw      (data_rw),
        .data_mode    (data_mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory stand-in (samples on negedge) ----------------
    logic [31:0] env_mem [0:WORDS-1];
    logic [31:0] env_rd;

    initial begin
        for (int i = 0; i < WORDS; i++) env_mem[i] = 32'd0;
        env_rd = 32'd0;
    end

    always @(negedge clk) begin
        logic [31:0] w;
        int          k;
        w = env_mem[data_address[13:2]];
        k = int'(data_address[1:0]);
        if (data_cs) begin
            if (data_rw) begin
                case (data_mode)
                    2'd0: w[31-8*k -: 8] = data_bus[7:0];
                    2'd1: if (k == 0) w[31:16] = data_bus[15:0];
                          else        w[15:0]  = data_bus[15:0];
                    default: w = data_bus;
                endcase
                env_mem[data_address[13:2]] <= w;
            end else begin
                env_rd <= w;
            end
        end
    end

    assign data_bus = (data_cs && !data_rw) ? env_rd : 32'bz;

    // ---------------- reference model: byte-addressed memory -------------
    logic [7:0]  ref_b [logic [31:0]];
    logic [32:0] exp_q [$];

    function automatic logic [7:0] rd_b(input logic [31:0] a);
        return ref_b.exists(a) ? ref_b[a] : 8'h00;
    endfunction

    task automatic model(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rw, input logic [1:0] mode, input logic sgn,
                         output logic [31:0] rdata, output logic err);
        int          n;
        logic [63:0] a64;
        logic [63:0] hi;
        logic [31:0] v;
        n   = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
        a64 = {32'b0, addr};
        hi  = {32'b0, BASE} + 64'(4 * WORDS) - 64'd1;
        err = (mode == 2'd3) || ((addr % n) != 0) || (a64 < {32'b0, BASE}) || (a64 > hi);
        rdata = 32'd0;
        if (!err) begin
            if (rw) begin
                for (int i = 0; i < n; i++) ref_b[addr + i] = wdata[8*(n-1-i) +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = (v << 8) | {24'b0, rd_b(addr + i)};
                if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                rdata = v;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (reset_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                fail("unexpected_resp");
            end else begin
                check("cmp_rdata", resp_rdata, exp_q[0][31:0]);
                check("cmp_error", {31'b0, resp_error}, {31'b0, exp_q[0][32]});
                check("cmp_req_ready_low", {31'b0, req_ready}, 32'd0);
                if (resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic rw, input logic [1:0] mode, input logic sgn,
                          input logic [31:0] lit_rdata, input logic lit_err,
                          input int hold);
        logic [31:0] m_rd;
        logic        m_err;
        logic [31:0] held;
        int          m;
        m = 0;
        @(negedge clk);
        while (!req_ready && m < 20) begin
            @(negedge clk);
            m++;
        end
        if (!req_ready) begin
            fail("req_ready_wait");
            return;
        end
        req_valid  = 1'b1;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rw     = rw;
        req_mode   = mode;
        req_signed = sgn;
        @(posedge clk);
        #1;
        // Scramble inputs so only the latched copy can produce the result.
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = ~wdata;
        req_rw    = ~rw;
        req_mode  = 2'd3;
        if (hold > 0) resp_ready = 1'b0;
        model(addr, wdata, rw, mode, sgn, m_rd, m_err);
        check("model_vs_literal_rdata", m_rd, lit_rdata);
        check("model_vs_literal_error", {31'b0, m_err}, {31'b0, lit_err});
        exp_q.push_back({m_err, m_rd});

        m = 0;
        @(negedge clk);
        check("data_cs", {31'b0, data_cs}, {31'b0, !m_err});
        if (!m_err) begin
            check("data_address", data_address, addr);
            check("data_rw", {31'b0, data_rw}, {31'b0, rw});
            check("data_mode", {30'b0, data_mode}, {30'b0, mode});
            if (rw) check("data_bus_store", data_bus, wdata);
        end
        while (!resp_valid && m < 10) begin
            @(negedge clk);
            m++;
        end
        if (!resp_valid) begin
            fail("resp_valid_wait");
            return;
        end
        check("latency", m + 1, m_err ? 32'd1 : 32'd2);
        check("lit_rdata", resp_rdata, lit_rdata);
        check("lit_error", {31'b0, resp_error}, {31'b0, lit_err});

        if (hold > 0) begin
            held = resp_rdata;
            repeat (hold) begin
                @(negedge clk);
                // A request offered while busy must be ignored.
                req_valid = 1'b1;
                req_addr  = BASE;
                req_mode  = 2'd2;
                check("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
                check("hold_rdata", resp_rdata, held);
                check("hold_req_ready", {31'b0, req_ready}, 32'd0);
            end
            @(posedge clk);
            #1;
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("release_resp_valid", {31'b0, resp_valid}, 32'd0);
            check("release_req_ready", {31'b0, req_ready}, 32'd1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rw     = 1'b0;
        req_mode   = 2'd0;
        req_signed = 1'b0;
        resp_ready = 1'b1;

        #12;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_error", {31'b0, resp_error}, 32'd0);
        check("rst_data_cs", {31'b0, data_cs}, 32'd0);
        check("rst_data_address", data_address, 32'd0);
        check("rst_data_rw_mode", {29'b0, data_rw, data_mode}, 32'd0);
        #11 reset_n = 1'b1;

        // Word store / load
        do_req(32'h8000_0000, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 32'h0000_0000, 1'b0, 0);
        do_req(32'h8000_0000, 32'h0,         1'b0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 0);
        // Byte / half extraction and extension
        do_req(32'h8000_0001, 32'h0, 1'b0, 2'd0, 1'b1, 32'hFFFF_FFAD, 1'b0, 0);
        do_req(32'h8000_0001, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0000_00AD, 1'b0, 0);
        do_req(32'h8000_0002, 32'h0, 1'b0, 2'd1, 1'b1, 32'hFFFF_BEEF, 1'b0, 0);
        do_req(32'h8000_0000, 32'h0, 1'b0, 2'd1, 1'b0, 32'h0000_DEAD, 1'b0, 0);
        do_req(32'h8000_0003, 32'h0, 1'b0, 2'd0, 1'b1, 32'hFFFF_FFEF, 1'b0, 0);
        // Byte store merged, read back immediately
        do_req(32'h8000_0003, 32'h0000_0011, 1'b1, 2'd0, 1'b0, 32'h0000_0000, 1'b0, 0);
        do_req(32'h8000_0000, 32'h0,         1'b0, 2'd2, 1'b0, 32'hDEAD_BE11, 1'b0, 0);
        // Half store into lower lane, positive/negative extension
        do_req(32'h8000_0006, 32'h0000_8001, 1'b1, 2'd1, 1'b0, 32'h0000_0000, 1'b0, 0);
        do_req(32'h8000_0006, 32'h0, 1'b0, 2'd1, 1'b1, 32'hFFFF_8001, 1'b0, 0);
        do_req(32'h8000_0006, 32'h0, 1'b0, 2'd0, 1'b1, 32'hFFFF_FF80, 1'b0, 0);
        do_req(32'h8000_0007, 32'h0, 1'b0, 2'd0, 1'b1, 32'h0000_0001, 1'b0, 0);
        // Last word of the window
        do_req(32'h8000_3FFC, 32'h0BAD_F00D, 1'b1, 2'd2, 1'b0, 32'h0000_0000, 1'b0, 0);
        do_req(32'h8000_3FFC, 32'h0,         1'b0, 2'd2, 1'b0, 32'h0BAD_F00D, 1'b0, 0);
        // Errors: misaligned, illegal mode, below and above the window
        do_req(32'h8000_0001, 32'h0, 1'b0, 2'd1, 1'b0, 32'h0, 1'b1, 0);
        do_req(32'h8000_0002, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 0);
        do_req(32'h8000_0000, 32'h0, 1'b0, 2'd3, 1'b0, 32'h0, 1'b1, 0);
        do_req(32'h7FFF_FFFC, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 0);
        do_req(32'h8000_4000, 32'h0, 1'b1, 2'd2, 1'b0, 32'h0, 1'b1, 0);
        // Back-pressure on the response
        do_req(32'h8000_0000, 32'h0, 1'b0, 2'd2, 1'b0, 32'hDEAD_BE11, 1'b0, 5);

        // Reset during the access cycle, before the memory negedge
        @(negedge clk);
        if (!req_ready) fail("reset_test_ready");
        req_valid = 1'b1;
        req_addr  = 32'h8000_0008;
        req_wdata = 32'h1234_5678;
        req_rw    = 1'b1;
        req_mode  = 2'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("pre_reset_cs", {31'b0, data_cs}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_cs", {31'b0, data_cs}, 32'd0);
        check("async_rst_rw", {31'b0, data_rw}, 32'd0);
        check("async_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        // Store was never committed
        do_req(32'h8000_0008, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0000_0000, 1'b0, 0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) fail("responses_outstanding");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
